// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked EX-stage ALU with registered results and an iterative mul/div engine.
// Build option: define ALU_SEQ_DIV_EN to include the restoring divider (DIV/DIVU), else they are undefined opcodes.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             DivZero
);
    localparam logic [5:0] OP_ADD    = 6'b100000, OP_SUB  = 6'b100010, OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR     = 6'b100101, OP_NOR  = 6'b100111, OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_SLL    = 6'b000000, OP_SRL  = 6'b111111, OP_SRA  = 6'b000010;
    localparam logic [5:0] OP_SLT    = 6'b101010, OP_SLTU = 6'b101011, OP_JR   = 6'b001000;
    localparam logic [5:0] OP_BEQ    = 6'b000100, OP_BNE  = 6'b000101, OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_BLEZ   = 6'b000110, OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_MUL    = 6'b011000, OP_MULT = 6'b011001, OP_MULTU = 6'b011100;
    localparam logic [5:0] OP_DIV    = 6'b011010, OP_DIVU = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] p_q;
    logic [WIDTH-1:0]   m_q;
    logic               neg_q;
    logic               in_ready_q, out_valid_q, zero_q, divzero_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;
`ifdef ALU_SEQ_DIV_EN
    logic               div_q, nega_q, bzero_q;
    logic [WIDTH-1:0]   a_q;
`endif

    logic is_mul, is_div, is_signed, sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    always_comb begin
        is_mul    = (ALUControl == OP_MUL) || (ALUControl == OP_MULT) || (ALUControl == OP_MULTU);
        is_signed = (ALUControl == OP_MUL) || (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
`ifdef ALU_SEQ_DIV_EN
        is_div    = (ALUControl == OP_DIV) || (ALUControl == OP_DIVU);
`else
        is_div    = 1'b0;
`endif
        sgn_a = is_signed & A[WIDTH-1];
        sgn_b = is_signed & B[WIDTH-1];
        mag_a = sgn_a ? -A : A;
        mag_b = sgn_b ? -B : B;
    end

    logic [WIDTH-1:0] sc_res;
    logic             sc_zero, sc_arith;
    logic [CNT_W-2:0] shamt;
    always_comb begin
        shamt    = A[CNT_W-2:0];
        sc_res   = '0;
        sc_zero  = 1'b0;
        sc_arith = ALUControl inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLL,
                                      OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_JR};
        case (ALUControl)
            OP_ADD:    sc_res = A + B;
            OP_SUB:    sc_res = A - B;
            OP_AND:    sc_res = A & B;
            OP_OR:     sc_res = A | B;
            OP_NOR:    sc_res = ~(A | B);
            OP_XOR:    sc_res = A ^ B;
            OP_SLL:    sc_res = B << shamt;
            OP_SRL:    sc_res = B >> shamt;
            OP_SRA:    sc_res = $signed(B) >>> shamt;
            OP_SLT:    sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:   sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_JR:     sc_res = A;
            OP_BEQ:    sc_zero = (A == B);
            OP_BNE:    sc_zero = (A != B);
            OP_BGTZ:   sc_zero = ~A[WIDTH-1] & (|A);
            OP_BLEZ:   sc_zero = A[WIDTH-1] | ~(|A);
            OP_REGIMM: begin
                if (B == WIDTH'(1))  sc_zero = ~A[WIDTH-1];
                else if (B == '0)    sc_zero = A[WIDTH-1];
            end
            default: ;
        endcase
        if (sc_arith) sc_zero = (sc_res == '0);
    end

    // Multiply: p_q = {partial sum, remaining multiplier bits}; add then shift right once per cycle.
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] mul_next, mul_fin;
    always_comb begin
        mul_upper = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_next  = {mul_upper, p_q[WIDTH-1:1]};
        mul_fin   = neg_q ? -mul_next : mul_next;
    end

`ifdef ALU_SEQ_DIV_EN
    // Divide: p_q = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fin, rem_fin;
    always_comb begin
        div_trial = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        div_next  = div_trial[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        quo_fin   = neg_q  ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        rem_fin   = nega_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        if (bzero_q) begin
            quo_fin = '1;
            rem_fin = a_q;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            m_q         <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            divzero_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q       <= 1'b0;
            nega_q      <= 1'b0;
            bzero_q     <= 1'b0;
            a_q         <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (In_Valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (is_mul || is_div) begin
                            state_q <= S_BUSY;
                            cnt_q   <= CNT_W'(WIDTH);
                            neg_q   <= sgn_a ^ sgn_b;
                            if (is_div) begin
                                p_q <= {{WIDTH{1'b0}}, mag_a};
                                m_q <= mag_b;
                            end else begin
                                p_q <= {{WIDTH{1'b0}}, mag_b};
                                m_q <= mag_a;
                            end
`ifdef ALU_SEQ_DIV_EN
                            div_q   <= is_div;
                            nega_q  <= sgn_a;
                            bzero_q <= (B == '0);
                            a_q     <= A;
`endif
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= sc_res;
                            result_hi_q <= '0;
                            zero_q      <= sc_zero;
                            divzero_q   <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    p_q   <= div_q ? div_next : mul_next;
`else
                    p_q   <= mul_next;
`endif
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_fin[WIDTH-1:0];
                        result_hi_q <= mul_fin[2*WIDTH-1:WIDTH];
                        zero_q      <= (mul_fin[WIDTH-1:0] == '0);
                        divzero_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
                        if (div_q) begin
                            result_q    <= quo_fin;
                            result_hi_q <= rem_fin;
                            zero_q      <= (quo_fin == '0);
                            divzero_q   <= bzero_q;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (Out_Ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign In_Ready  = in_ready_q;
    assign Out_Valid = out_valid_q;
    assign Result    = result_q;
    assign ResultHi  = result_hi_q;
    assign Zero      = zero_q;
    assign DivZero   = divzero_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH=32); divide checks follow ALU_SEQ_DIV_EN.
module tb_alu_seq_unit;
    localparam int W = 32;
    localparam logic [5:0] OP_ADD = 6'b100000, OP_SUB = 6'b100010, OP_SLL = 6'b000000;
    localparam logic [5:0] OP_SRL = 6'b111111, OP_SRA = 6'b000010, OP_SLT = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011, OP_JR = 6'b001000, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_BGTZ = 6'b000111, OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_REGIMM = 6'b000001, OP_MUL = 6'b011000, OP_MULT = 6'b011001;
    localparam logic [5:0] OP_MULTU = 6'b011100, OP_DIV = 6'b011010, OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_UNDEF = 6'b111110;

    logic         Clk = 1'b0, Rst_n = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b0;
    logic         In_Ready, Out_Valid, Zero, DivZero;
    logic [5:0]   ALUControl = '0;
    logic [W-1:0] A = '0, B = '0, Result, ResultHi;
    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    alu_seq_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .ALUControl(ALUControl), .A(A), .B(B), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Result(Result), .ResultHi(ResultHi), .Zero(Zero), .DivZero(DivZero)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat);
        int n = 0;
        int lat;
        while (In_Ready !== 1'b1 && n < 100) begin @(posedge Clk); #1; n++; end
        chk({tag, " in_ready"}, W'(In_Ready), 1);
        ALUControl = op; A = a; B = b; In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        lat = 1;
        while (Out_Valid !== 1'b1 && lat < 100) begin @(posedge Clk); #1; lat++; end
        chk({tag, " latency"}, W'(lat), W'(exp_lat));
        chk({tag, " in_ready low"}, W'(In_Ready), 0);
    endtask

    task automatic finish_op(input string tag);
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
        chk({tag, " out_valid drop"}, W'(Out_Valid), 0);
        chk({tag, " in_ready back"}, W'(In_Ready), 1);
    endtask

    task automatic op(input string tag, input logic [5:0] opc, input logic [W-1:0] a,
                      input logic [W-1:0] b, input int lat, input logic [W-1:0] res,
                      input logic [W-1:0] hi, input logic zero, input logic dz);
        run_op(tag, opc, a, b, lat);
        chk({tag, " result"}, Result, res);
        chk({tag, " result_hi"}, ResultHi, hi);
        chk({tag, " zero"}, W'(Zero), W'(zero));
        chk({tag, " divzero"}, W'(DivZero), W'(dz));
        finish_op(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst out_valid", W'(Out_Valid), 0);
        chk("rst result", Result, 0);
        chk("rst result_hi", ResultHi, 0);
        chk("rst zero", W'(Zero), 0);
        chk("rst divzero", W'(DivZero), 0);
        chk("rst in_ready", W'(In_Ready), 0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("in_ready after release", W'(In_Ready), 1);

        op("add wrap", OP_ADD, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 0, 1'b0, 1'b0);
        op("sub zero", OP_SUB, 32'd5, 32'd5, 1, 0, 0, 1'b1, 1'b0);
        op("jr", OP_JR, 32'h1234, 32'h9, 1, 32'h1234, 0, 1'b0, 1'b0);
        op("sll", OP_SLL, 32'd4, 32'h1, 1, 32'h10, 0, 1'b0, 1'b0);
        op("sll shamt mask", OP_SLL, 32'h24, 32'h1, 1, 32'h10, 0, 1'b0, 1'b0);
        op("srl", OP_SRL, 32'd4, 32'h80000000, 1, 32'h08000000, 0, 1'b0, 1'b0);
        op("sra", OP_SRA, 32'd4, 32'h80000000, 1, 32'hF8000000, 0, 1'b0, 1'b0);
        op("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h1, 1, 0, 0, 1'b1, 1'b0);
        op("slt", OP_SLT, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 0, 1'b0, 1'b0);
        op("bgez", OP_REGIMM, 32'h0, 32'h1, 1, 0, 0, 1'b1, 1'b0);
        op("bltz", OP_REGIMM, 32'h80000000, 32'h0, 1, 0, 0, 1'b1, 1'b0);
        op("regimm other", OP_REGIMM, 32'h80000000, 32'h2, 1, 0, 0, 1'b0, 1'b0);
        op("blez", OP_BLEZ, 32'h1, 32'h0, 1, 0, 0, 1'b0, 1'b0);
        op("bgtz neg", OP_BGTZ, 32'h80000000, 32'h0, 1, 0, 0, 1'b0, 1'b0);
        op("bgtz pos", OP_BGTZ, 32'h5, 32'h0, 1, 0, 0, 1'b1, 1'b0);
        op("beq", OP_BEQ, 32'h3, 32'h3, 1, 0, 0, 1'b1, 1'b0);
        op("bne", OP_BNE, 32'h3, 32'h3, 1, 0, 0, 1'b0, 1'b0);
        op("undef", OP_UNDEF, 32'h3, 32'h4, 1, 0, 0, 1'b0, 1'b0);

        op("mult", OP_MULT, 32'hFFFFFFFE, 32'h3, 33, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0);
        op("multu", OP_MULTU, 32'hFFFFFFFE, 32'h3, 33, 32'hFFFFFFFA, 32'h2, 1'b0, 1'b0);
        op("mul", OP_MUL, 32'h10000, 32'h10000, 33, 0, 32'h1, 1'b1, 1'b0);
`ifdef ALU_SEQ_DIV_EN
        op("div", OP_DIV, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
        op("divu by zero", OP_DIVU, 32'h7, 32'h0, 33, 32'hFFFFFFFF, 32'h7, 1'b0, 1'b1);
        op("div min by -1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 0, 1'b0, 1'b0);
`else
        op("div disabled", OP_DIV, 32'hFFFFFFF9, 32'h2, 1, 0, 0, 1'b0, 1'b0);
        op("divu disabled", OP_DIVU, 32'h7, 32'h0, 1, 0, 0, 1'b0, 1'b0);
`endif

        run_op("bp", OP_ADD, 32'h1, 32'h2, 1);
        for (int i = 0; i < 5; i++) begin
            ALUControl = OP_SUB; A = 32'h9; B = 32'h9; In_Valid = 1'b1;
            @(posedge Clk); #1;
            chk("bp result held", Result, 32'h3);
            chk("bp out_valid held", W'(Out_Valid), 1);
            chk("bp in_ready low", W'(In_Ready), 0);
        end
        In_Valid = 1'b0;
        finish_op("bp");
        @(posedge Clk); #1;
        chk("bp no ghost op", W'(Out_Valid), 0);

        ALUControl = OP_MULT; A = 32'h7; B = 32'h5; In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        chk("busy out_valid", W'(Out_Valid), 0);
        Rst_n = 1'b0;
        #1;
        chk("async rst result", Result, 0);
        chk("async rst result_hi", ResultHi, 0);
        chk("async rst out_valid", W'(Out_Valid), 0);
        chk("async rst in_ready", W'(In_Ready), 0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("in_ready after mid reset", W'(In_Ready), 1);
        op("add after reset", OP_ADD, 32'h2, 32'h3, 1, 32'h5, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
